// File: rtl/ctrl_pipe.sv
// Control-word pipeline (stage 0=E, 1=M, 2=W, ...) with per-stage stall/flush and a
// multicycle-op FSM that pins stage 0 for MC_CYCLES cycles.
module ctrl_pipe #(
    parameter int unsigned CW          = 8,
    parameter int unsigned NSTAGE      = 3,
    parameter int unsigned MC_CYCLES   = 4,
    parameter bit          BUBBLE_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        ctrl_d,
    input  logic                 valid_d,
    input  logic                 mc_d,
    input  logic [NSTAGE-1:0]    stall,
    input  logic [NSTAGE-1:0]    flush,
    output logic [NSTAGE*CW-1:0] ctrl_q,
    output logic [NSTAGE-1:0]    valid_q,
    output logic                 stall_req,
    output logic                 mc_busy
);
    localparam int unsigned     CntW    = $clog2(MC_CYCLES);
    localparam logic [CntW-1:0] CntInit = CntW'(MC_CYCLES - 2);

    typedef enum logic {StIdle, StBusy} mcStateT;

    mcStateT                   stateQ, stateD;
    logic [CntW-1:0]           countQ, countD;
    logic [NSTAGE-1:0][CW-1:0] stageCtrlQ, stageCtrlD;
    logic [NSTAGE-1:0]         stageValidQ, stageValidD;
    logic [NSTAGE:0]           holdChain;
    logic [NSTAGE-1:0]         hold;
    logic                      busy;
    logic                      advance0;

    assign busy      = (stateQ == StBusy);
    assign stall_req = busy;
    assign mc_busy   = busy;

    // An older stage holding forces every younger stage to hold as well.
    always_comb begin
        holdChain = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            holdChain[k] = stall[k] | holdChain[k+1];
        end
        holdChain[0] = holdChain[0] | busy;
    end

    assign hold     = holdChain[NSTAGE-1:0];
    assign advance0 = !flush[0] && !hold[0];

    always_comb begin
        stageCtrlD  = stageCtrlQ;
        stageValidD = stageValidQ;
        if (flush[0]) begin
            stageCtrlD[0]  = '0;
            stageValidD[0] = 1'b0;
        end else if (!hold[0]) begin
            stageCtrlD[0]  = ctrl_d;
            stageValidD[0] = valid_d;
        end
        for (int k = 1; k < NSTAGE; k++) begin
            // Advancing behind a holding stage takes a bubble.
            if (flush[k] || (!hold[k] && hold[k-1])) begin
                stageCtrlD[k]  = '0;
                stageValidD[k] = 1'b0;
            end else if (!hold[k]) begin
                stageCtrlD[k]  = stageCtrlQ[k-1];
                stageValidD[k] = stageValidQ[k-1];
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        countD = countQ;
        unique case (stateQ)
            StIdle: begin
                if (advance0 && valid_d && mc_d) begin
                    stateD = StBusy;
                    countD = CntInit;
                end
            end
            StBusy: begin
                if (flush[0]) begin
                    stateD = StIdle;
                    countD = '0;
                end else if (countQ == '0) begin
                    stateD = StIdle;
                end else begin
                    countD = countQ - CntW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ      <= StIdle;
            countQ      <= '0;
            stageCtrlQ  <= '0;
            stageValidQ <= '0;
        end else begin
            stateQ      <= stateD;
            countQ      <= countD;
            stageCtrlQ  <= stageCtrlD;
            stageValidQ <= stageValidD;
        end
    end

    always_comb begin
        ctrl_q = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (stageValidQ[k] || !BUBBLE_ZERO) begin
                ctrl_q[k*CW +: CW] = stageCtrlQ[k];
            end
        end
    end

    assign valid_q = stageValidQ;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe (CW=8, NSTAGE=3, MC_CYCLES=4): per-cycle stimulus and
// hand-derived expected pipe snapshots are queued, then applied and compared each edge.
module tb_ctrl_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ctrl_d = '0;
    logic        valid_d = 1'b0;
    logic        mc_d = 1'b0;
    logic [2:0]  stall = '0;
    logic [2:0]  flush = '0;
    logic [23:0] ctrl_q;
    logic [2:0]  valid_q;
    logic        stall_req;
    logic        mc_busy;

    int checkCnt = 0;
    int passCnt  = 0;

    ctrl_pipe #(
        .CW(8),
        .NSTAGE(3),
        .MC_CYCLES(4),
        .BUBBLE_ZERO(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctrl_d(ctrl_d),
        .valid_d(valid_d),
        .mc_d(mc_d),
        .stall(stall),
        .flush(flush),
        .ctrl_q(ctrl_q),
        .valid_q(valid_q),
        .stall_req(stall_req),
        .mc_busy(mc_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cd;
        logic        vd;
        logic        md;
        logic [2:0]  st;
        logic [2:0]  fl;
        logic [23:0] eCtrl;
        logic [2:0]  eValid;
        logic        eBusy;
    } stepT;

    stepT sbq[$];

    function automatic stepT mk(input logic [7:0] cd, input logic vd, input logic md,
                                input logic [2:0] st, input logic [2:0] fl,
                                input logic [7:0] w, input logic [7:0] m, input logic [7:0] e,
                                input logic [2:0] ev, input logic eb);
        stepT s;
        s.cd = cd; s.vd = vd; s.md = md; s.st = st; s.fl = fl;
        s.eCtrl = {w, m, e}; s.eValid = ev; s.eBusy = eb;
        return s;
    endfunction

    task automatic apply(input stepT s);
        ctrl_d = s.cd; valid_d = s.vd; mc_d = s.md; stall = s.st; flush = s.fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checkCnt++;
        if ({ctrl_q, valid_q, stall_req, mc_busy} !== 29'd0)
            $display("FAIL reset_initial: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected all 0",
                     ctrl_q, valid_q, stall_req, mc_busy);
        else passCnt++;
        ctrl_d = 8'hFF; valid_d = 1'b1;
        tick();
        checkCnt++;
        if ({ctrl_q, valid_q, stall_req, mc_busy} !== 29'd0)
            $display("FAIL reset_held_over_edge: got ctrl_q=%h valid_q=%b, expected 0 0", ctrl_q, valid_q);
        else passCnt++;
        ctrl_d = '0; valid_d = 1'b0;
        #1 rst = 1'b1;
    endtask

    task automatic test_flow();
        stepT s; int n = 0;
        sbq.push_back(mk(8'hA5, 1, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'hA5, 3'b001, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'hA5, 8'h00, 3'b010, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'hA5, 8'h00, 8'h00, 3'b100, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0));
        while (sbq.size() != 0) begin
            s = sbq.pop_front(); apply(s); tick(); n++; checkCnt++;
            if ({ctrl_q, valid_q, stall_req, mc_busy} !== {s.eCtrl, s.eValid, s.eBusy, s.eBusy})
                $display("FAIL flow step %0d: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected %h %b %b",
                         n, ctrl_q, valid_q, stall_req, mc_busy, s.eCtrl, s.eValid, s.eBusy);
            else passCnt++;
        end
    endtask

    task automatic test_stall();
        stepT s; int n = 0;
        sbq.push_back(mk(8'h33, 1, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h33, 3'b001, 0));
        sbq.push_back(mk(8'h22, 1, 0, 3'b000, 3'b000, 8'h00, 8'h33, 8'h22, 3'b011, 0));
        sbq.push_back(mk(8'h11, 1, 0, 3'b000, 3'b000, 8'h33, 8'h22, 8'h11, 3'b111, 0));
        sbq.push_back(mk(8'h44, 1, 0, 3'b010, 3'b000, 8'h00, 8'h22, 8'h11, 3'b011, 0));
        sbq.push_back(mk(8'h44, 1, 0, 3'b000, 3'b000, 8'h22, 8'h11, 8'h44, 3'b111, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h11, 8'h44, 8'h00, 3'b110, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h44, 8'h00, 8'h00, 3'b100, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0));
        while (sbq.size() != 0) begin
            s = sbq.pop_front(); apply(s); tick(); n++; checkCnt++;
            if ({ctrl_q, valid_q, stall_req, mc_busy} !== {s.eCtrl, s.eValid, s.eBusy, s.eBusy})
                $display("FAIL stall step %0d: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected %h %b %b",
                         n, ctrl_q, valid_q, stall_req, mc_busy, s.eCtrl, s.eValid, s.eBusy);
            else passCnt++;
        end
    endtask

    task automatic test_flush_over_stall();
        stepT s; int n = 0;
        sbq.push_back(mk(8'h55, 1, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h55, 3'b001, 0));
        sbq.push_back(mk(8'h66, 1, 0, 3'b000, 3'b000, 8'h00, 8'h55, 8'h66, 3'b011, 0));
        sbq.push_back(mk(8'h77, 1, 0, 3'b000, 3'b000, 8'h55, 8'h66, 8'h77, 3'b111, 0));
        sbq.push_back(mk(8'h88, 1, 0, 3'b001, 3'b001, 8'h66, 8'h00, 8'h00, 3'b100, 0));
        sbq.push_back(mk(8'h88, 1, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h88, 3'b001, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h88, 8'h00, 3'b010, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h88, 8'h00, 8'h00, 3'b100, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0));
        while (sbq.size() != 0) begin
            s = sbq.pop_front(); apply(s); tick(); n++; checkCnt++;
            if ({ctrl_q, valid_q, stall_req, mc_busy} !== {s.eCtrl, s.eValid, s.eBusy, s.eBusy})
                $display("FAIL flush_over_stall step %0d: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected %h %b %b",
                         n, ctrl_q, valid_q, stall_req, mc_busy, s.eCtrl, s.eValid, s.eBusy);
            else passCnt++;
        end
    endtask

    task automatic test_multicycle();
        stepT s; int n = 0;
        sbq.push_back(mk(8'h5C, 1, 1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 1));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 1));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 1));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 0));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b000, 3'b000, 8'h00, 8'h5C, 8'hC3, 3'b011, 1));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h5C, 8'h00, 8'hC3, 3'b101, 1));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'hC3, 3'b001, 1));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'hC3, 3'b001, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'hC3, 8'h00, 3'b010, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'hC3, 8'h00, 8'h00, 3'b100, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0));
        while (sbq.size() != 0) begin
            s = sbq.pop_front(); apply(s); tick(); n++; checkCnt++;
            if ({ctrl_q, valid_q, stall_req, mc_busy} !== {s.eCtrl, s.eValid, s.eBusy, s.eBusy})
                $display("FAIL multicycle step %0d: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected %h %b %b",
                         n, ctrl_q, valid_q, stall_req, mc_busy, s.eCtrl, s.eValid, s.eBusy);
            else passCnt++;
        end
    endtask

    task automatic test_mc_ext_stall();
        stepT s; int n = 0;
        sbq.push_back(mk(8'h5C, 1, 1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 1));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b001, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 1));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b001, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 1));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b001, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 0));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b001, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h5C, 8'h00, 3'b010, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h5C, 8'h00, 8'h00, 3'b100, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0));
        while (sbq.size() != 0) begin
            s = sbq.pop_front(); apply(s); tick(); n++; checkCnt++;
            if ({ctrl_q, valid_q, stall_req, mc_busy} !== {s.eCtrl, s.eValid, s.eBusy, s.eBusy})
                $display("FAIL mc_ext_stall step %0d: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected %h %b %b",
                         n, ctrl_q, valid_q, stall_req, mc_busy, s.eCtrl, s.eValid, s.eBusy);
            else passCnt++;
        end
    endtask

    task automatic test_abort();
        stepT s; int n = 0;
        sbq.push_back(mk(8'h5C, 1, 1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 1));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h5C, 3'b001, 1));
        sbq.push_back(mk(8'hC3, 1, 1, 3'b000, 3'b001, 8'h00, 8'h00, 8'h00, 3'b000, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0));
        while (sbq.size() != 0) begin
            s = sbq.pop_front(); apply(s); tick(); n++; checkCnt++;
            if ({ctrl_q, valid_q, stall_req, mc_busy} !== {s.eCtrl, s.eValid, s.eBusy, s.eBusy})
                $display("FAIL abort step %0d: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected %h %b %b",
                         n, ctrl_q, valid_q, stall_req, mc_busy, s.eCtrl, s.eValid, s.eBusy);
            else passCnt++;
        end
        checkCnt++;
        if (dut.countQ !== 2'd0)
            $display("FAIL abort_count: got count=%0d, expected 0", dut.countQ);
        else passCnt++;
    endtask

    task automatic test_async_reset();
        stepT s; int n = 0;
        sbq.push_back(mk(8'h11, 1, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h11, 3'b001, 0));
        sbq.push_back(mk(8'h22, 1, 0, 3'b000, 3'b000, 8'h00, 8'h11, 8'h22, 3'b011, 0));
        sbq.push_back(mk(8'h33, 1, 1, 3'b000, 3'b000, 8'h11, 8'h22, 8'h33, 3'b111, 1));
        while (sbq.size() != 0) begin
            s = sbq.pop_front(); apply(s); tick(); n++; checkCnt++;
            if ({ctrl_q, valid_q, stall_req, mc_busy} !== {s.eCtrl, s.eValid, s.eBusy, s.eBusy})
                $display("FAIL async_fill step %0d: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected %h %b %b",
                         n, ctrl_q, valid_q, stall_req, mc_busy, s.eCtrl, s.eValid, s.eBusy);
            else passCnt++;
        end
        #2 rst = 1'b0;
        #1;
        checkCnt++;
        if ({ctrl_q, valid_q, stall_req, mc_busy} !== 29'd0)
            $display("FAIL async_reset_midbusy: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected all 0",
                     ctrl_q, valid_q, stall_req, mc_busy);
        else passCnt++;
        ctrl_d = '0; valid_d = 1'b0; mc_d = 1'b0;
        #1 rst = 1'b1;
        n = 0;
        sbq.push_back(mk(8'h77, 1, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h77, 3'b001, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h77, 8'h00, 3'b010, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h77, 8'h00, 8'h00, 3'b100, 0));
        sbq.push_back(mk(8'h00, 0, 0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0));
        while (sbq.size() != 0) begin
            s = sbq.pop_front(); apply(s); tick(); n++; checkCnt++;
            if ({ctrl_q, valid_q, stall_req, mc_busy} !== {s.eCtrl, s.eValid, s.eBusy, s.eBusy})
                $display("FAIL async_resume step %0d: got ctrl_q=%h valid_q=%b stall_req=%b mc_busy=%b, expected %h %b %b",
                         n, ctrl_q, valid_q, stall_req, mc_busy, s.eCtrl, s.eValid, s.eBusy);
            else passCnt++;
        end
    endtask

    initial begin
        test_reset();
        test_flow();
        test_stall();
        test_flush_over_stall();
        test_multicycle();
        test_mc_ext_stall();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
